// File: rtl/vec_data_mem.sv
// Shared scalar/vector data memory: one array of LANES x ELEM_W rows, fair two-port arbitration.
// Optional LED/switch MMIO region is enabled by defining VEC_DATA_MEM_MMIO_EN.
module vec_data_mem #(
    parameter int          LANES     = 16,
    parameter int          ELEM_W    = 8,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_req,
    input  logic                      s_we,
    input  logic [31:0]               s_addr,
    input  logic [31:0]               s_wdata,
    output logic                      s_ready,
    output logic                      s_rvalid,
    output logic [31:0]               s_rdata,
    input  logic                      v_req,
    input  logic                      v_we,
    input  logic [$clog2(DEPTH)-1:0]  v_addr,
    input  logic [LANES*ELEM_W-1:0]   v_wdata,
    input  logic [LANES-1:0]          v_wmask,
    output logic                      v_ready,
    output logic                      v_rvalid,
    output logic [LANES*ELEM_W-1:0]   v_rdata,
    input  logic [SW_W-1:0]           sw_in,
    output logic [LED_W-1:0]          led_out
);

    localparam int          LANE_BITS  = $clog2(LANES);
    localparam int          ROW_BITS   = $clog2(DEPTH);
    localparam int          ROW_W      = LANES * ELEM_W;
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * LANES);

    function automatic logic [31:0] sext_elem(input logic [ELEM_W-1:0] e);
        logic [31:0] r;
        r             = {32{e[ELEM_W-1]}};
        r[ELEM_W-1:0] = e;
        return r;
    endfunction

    logic [ROW_W-1:0]     r_mem [DEPTH];
    logic                 r_prio_v;
    logic                 r_s_rvalid;
    logic                 r_v_rvalid;
    logic [31:0]          r_s_rdata;
    logic [ROW_W-1:0]     r_v_rdata;
    logic [SW_W-1:0]      r_sw_meta;
    logic [SW_W-1:0]      r_sw_sync;

    logic                 w_grant_s;
    logic                 w_grant_v;
    logic [ROW_BITS-1:0]  w_s_row;
    logic [LANE_BITS-1:0] w_s_lane;
    logic                 w_s_in_range;
    logic                 w_s_arr_wr;
    logic                 w_v_wr;
    logic [ROW_BITS-1:0]  w_rd_addr;
    logic [ROW_W-1:0]     w_rd_row;
    logic [31:0]          w_mmio_val;
    logic [31:0]          w_s_rd_val;
    logic                 w_unused_ok;

    // Priority flag picks the winner only when both ports ask; no grants while in reset.
    assign w_grant_v = reset & v_req & (~s_req | r_prio_v);
    assign w_grant_s = reset & s_req & (~v_req | ~r_prio_v);
    assign s_ready   = w_grant_s;
    assign v_ready   = w_grant_v;

    assign w_s_row      = s_addr[LANE_BITS +: ROW_BITS];
    assign w_s_lane     = s_addr[LANE_BITS-1:0];
    assign w_s_in_range = (s_addr < ADDR_LIMIT);
    assign w_s_arr_wr   = w_grant_s & s_we & w_s_in_range;
    assign w_v_wr       = w_grant_v & v_we;
    assign w_rd_addr    = w_grant_v ? v_addr : w_s_row;
    assign w_rd_row     = r_mem[w_rd_addr];

    // Array write port: vector writes honour the lane mask, scalar writes touch one lane
    always_ff @(posedge clk) begin
        if (w_v_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (v_wmask[i]) begin
                    r_mem[v_addr][i*ELEM_W +: ELEM_W] <= v_wdata[i*ELEM_W +: ELEM_W];
                end
            end
        end else if (w_s_arr_wr) begin
            r_mem[w_s_row][int'(w_s_lane)*ELEM_W +: ELEM_W] <= s_wdata[ELEM_W-1:0];
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sw_meta <= {SW_W{1'b0}};
            r_sw_sync <= {SW_W{1'b0}};
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

`ifdef VEC_DATA_MEM_MMIO_EN
    localparam logic [31:0] MMIO_SW_ADDR = MMIO_BASE + 32'd1;

    logic [LED_W-1:0] r_led;

    function automatic logic [31:0] zext_led(input logic [LED_W-1:0] x);
        logic [31:0] r;
        r            = 32'h0;
        r[LED_W-1:0] = x;
        return r;
    endfunction

    function automatic logic [31:0] zext_sw(input logic [SW_W-1:0] x);
        logic [31:0] r;
        r           = 32'h0;
        r[SW_W-1:0] = x;
        return r;
    endfunction

    // LED register loads on an accepted scalar write to MMIO_BASE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_led <= {LED_W{1'b0}};
        end else if (w_grant_s && s_we && (s_addr == MMIO_BASE)) begin
            r_led <= s_wdata[LED_W-1:0];
        end
    end

    // MMIO read decode; any other out-of-range address reads as zero
    always_comb begin
        w_mmio_val = 32'h0;
        if (s_addr == MMIO_BASE) begin
            w_mmio_val = zext_led(r_led);
        end else if (s_addr == MMIO_SW_ADDR) begin
            w_mmio_val = zext_sw(r_sw_sync);
        end else begin
            w_mmio_val = 32'h0;
        end
    end

    assign led_out = r_led;
`else
    assign w_mmio_val = 32'h0;
    assign led_out    = {LED_W{1'b0}};
`endif

    // Scalar read value: sign-extended element or the out-of-range/MMIO value
    always_comb begin
        w_s_rd_val = 32'h0;
        if (w_s_in_range) begin
            w_s_rd_val = sext_elem(w_rd_row[int'(w_s_lane)*ELEM_W +: ELEM_W]);
        end else begin
            w_s_rd_val = w_mmio_val;
        end
    end

    // Read-data registers load only on an accepted read and hold otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prio_v   <= 1'b1;
            r_s_rvalid <= 1'b0;
            r_v_rvalid <= 1'b0;
            r_s_rdata  <= 32'h0;
            r_v_rdata  <= {ROW_W{1'b0}};
        end else begin
            r_s_rvalid <= w_grant_s & ~s_we;
            r_v_rvalid <= w_grant_v & ~v_we;
            if (w_grant_s && !s_we) begin
                r_s_rdata <= w_s_rd_val;
            end
            if (w_grant_v && !v_we) begin
                r_v_rdata <= w_rd_row;
            end
            if (s_req && v_req) begin
                r_prio_v <= ~r_prio_v;
            end
        end
    end

    // A read in flight when reset goes low never reports valid
    assign s_rvalid = r_s_rvalid & reset;
    assign v_rvalid = r_v_rvalid & reset;
    assign s_rdata  = r_s_rdata;
    assign v_rdata  = r_v_rdata;

    assign w_unused_ok = ^{s_wdata, r_sw_sync, MMIO_BASE};

endmodule

// File: doc/vec_data_mem.md
# vec_data_mem

Parametrised data-memory controller serving the processor's scalar load/store port and its SIMD vector port from one shared array of LANES×ELEM_W-bit rows. It is the successor of the fixed 8-bit scalar RAM plus 128-bit vector RAM pair. It adds:
- lane count, element width and depth as parameters
- per-lane write masking
- fair arbitration between the two ports, with a ready handshake
- sign-extended scalar reads
- an optional memory-mapped LED/switch region

## Interface
Parameters:
- LANES, 16, elements per row; power of two, ≥2
- ELEM_W, 8, element width in bits; 1..32
- DEPTH, 1024, number of rows; power of two
- MMIO_BASE, 32'h0001_0000, scalar address of the LED register; must be ≥ DEPTH*LANES
- LED_W, 8, LED register width
- SW_W, 3, switch input width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- s_req  in  1  scalar request; held until accepted
- s_we  in  1  scalar write (1) / read (0)
- s_addr  in  32  scalar element address: row = s_addr / LANES, lane = s_addr % LANES
- s_wdata  in  32  scalar write data; low ELEM_W bits used
- s_ready  out  1  scalar request accepted this cycle
- s_rvalid  out  1  scalar read data valid
- s_rdata  out  32  scalar read data, sign-extended
- v_req  in  1  vector request; held until accepted
- v_we  in  1  vector write (1) / read (0)
- v_addr  in  $clog2(DEPTH)  row index
- v_wdata  in  LANES*ELEM_W  vector write data; lane i occupies bits [i*ELEM_W +: ELEM_W]
- v_wmask  in  LANES  per-lane write enable
- v_ready  out  1  vector request accepted this cycle
- v_rvalid  out  1  vector read data valid
- v_rdata  out  LANES*ELEM_W  vector read data
- sw_in  in  SW_W  asynchronous switch inputs
- led_out  out  LED_W  LED register

## Operation
- Storage is one single-ported array with synchronous read. At most one access is granted per cycle.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: the port named by the priority flag is granted, and the flag then flips to the other port.
  - The flag is "vector" after reset and changes only on a conflict.
- Handshake:
  - s_ready = s_req & grant_s; v_ready = v_req & grant_v.
  - A requester that is not granted must hold its request and all its fields stable.
- Scalar write to a row: writes lane (s_addr % LANES) with s_wdata[ELEM_W-1:0]; other lanes are unchanged.
- Scalar read from a row: returns the selected element sign-extended to 32 bits.
- Vector write: writes lane i only where v_wmask[i]=1. A mask of all zeros is a legal no-op that still handshakes.
- Vector read: returns the full row.
- Scalar address ≥ DEPTH*LANES is out of range:
  - Handled as MMIO when enabled (see Configuration).
  - Otherwise writes are discarded, and reads return 0 with s_rvalid asserted as usual.
- sw_in passes through a 2-flop synchroniser, whether or not MMIO is enabled.
- Memory contents are not reset.

## Timing
- Grant and ready are combinational from the current requests and the priority flag.
- Read latency is 1 cycle: the rvalid of a port pulses high for exactly one cycle, the cycle after its read is accepted. Writes produce no rvalid.
- s_rdata and v_rdata hold their last value until the next rvalid. Both are 0 after reset.
- A read accepted the cycle after a write to the same row returns the newly written data.
- Worst-case wait is 1 cycle per port under continuous contention. Back-to-back accepted requests are allowed every cycle.
- Reset values: s_ready/v_ready follow the reset-state grant; s_rvalid=0, v_rvalid=0, s_rdata=0, v_rdata=0, led_out=0; priority flag = vector; synchroniser flops = 0.
- Reset asserted while a read is in flight: the read's rvalid is suppressed.
- Requests present while reset is low are not granted: s_ready=0, v_ready=0.

## Configuration
- VEC_DATA_MEM_MMIO_EN defined:
  - Scalar write to MMIO_BASE loads led_out with s_wdata[LED_W-1:0]; it is visible the next cycle.
  - Scalar read of MMIO_BASE returns led_out zero-extended.
  - Scalar read of MMIO_BASE+1 returns the synchronised sw_in zero-extended.
  - MMIO accesses use the same arbitration and the same 1-cycle read latency as array accesses.
- Not defined: led_out is tied to 0, and MMIO_BASE/MMIO_BASE+1 behave as ordinary out-of-range addresses.

## Test plan
- Defaults; vector write row 3, data 16 bytes 8'h01..8'h10, mask 16'hFFFF; then scalar read of address 3*16+15 -> s_rvalid one cycle after accept, s_rdata = 32'h0000_0010.
- Vector write row 5 with mask 16'h00F0 over a row preloaded with 8'hAA, data all 8'h55; then vector read row 5 -> lanes 4..7 = 8'h55, all other lanes = 8'hAA.
- Scalar write 8'hF3 to address 7; then scalar read address 7 -> s_rdata = 32'hFFFF_FFF3.
- Both ports request continuously for 4 cycles straight out of reset -> grants alternate in order vector, scalar, vector, scalar; each ready is high exactly 2 cycles.
- With MMIO enabled: write 32'h0000_00A5 to MMIO_BASE -> led_out = 8'hA5 next cycle. Set sw_in = 3'b101, wait 2 cycles, read MMIO_BASE+1 -> 32'h5.
- Without MMIO enabled: the same accesses -> led_out stays 0 and the read returns 0.
- Issue a vector read, then drop reset the next cycle -> v_rvalid stays 0; v_rdata = 0 after reset.
